// File: rtl/tour_cmd.sv
// tour_cmd
// Sits between the UART wrapper and cmd_proc. In IDLE it forwards UART
// commands unchanged. After start_tour it replays a stored knight's tour.
// Each knight move is issued as two commands: first a vertical leg, then
// a horizontal leg. Each command is handed over with the same cmd_rdy /
// clr_cmd_rdy / send_resp handshake that a UART command uses.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start_tour          one-cycle pulse that starts the replay
//   move[7:0]           one-hot knight move for mv_indx, from the tour logic
//   mv_indx[4:0]        index of the move being replayed
//   cmd_UART[15:0]      command from the UART wrapper
//   cmd_rdy_UART        UART command valid
//   clr_cmd_rdy         cmd_proc has consumed cmd
//   send_resp           cmd_proc has finished and requests a response
//   cmd[15:0]           command to cmd_proc {opcode, heading, squares}
//   cmd_rdy             cmd valid to cmd_proc
//   clr_cmd_rdy_UART    consume strobe forwarded to the UART wrapper
//   resp[7:0]           response byte (8'hA5 done / 8'h5A in progress)
module tour_cmd #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        clr_cmd_rdy_UART,
    output logic [7:0]  resp
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] VERT  = 3'd1;
    localparam logic [2:0] HOLDV = 3'd2;
    localparam logic [2:0] HORZ  = 3'd3;
    localparam logic [2:0] HOLDH = 3'd4;

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    logic [2:0]  state_q,    state_d;
    logic [4:0]  mv_indx_q,  mv_indx_d;
    logic [15:0] last_cmd_q, last_cmd_d;

    // Decoded move: the lowest set bit wins. Each leg is kept as a sign
    // plus a magnitude.
    logic       dx_pos, dy_pos, move_none;
    logic [1:0] dx_mag, dy_mag;
    logic [15:0] vert_cmd, horz_cmd;
    logic       at_last;

    always_comb begin
        dx_pos    = 1'b0;
        dy_pos    = 1'b0;
        dx_mag    = 2'd0;
        dy_mag    = 2'd0;
        move_none = 1'b0;
        if      (move[0]) begin dx_pos = 1'b0; dx_mag = 2'd1; dy_pos = 1'b1; dy_mag = 2'd2; end
        else if (move[1]) begin dx_pos = 1'b1; dx_mag = 2'd1; dy_pos = 1'b1; dy_mag = 2'd2; end
        else if (move[2]) begin dx_pos = 1'b0; dx_mag = 2'd2; dy_pos = 1'b1; dy_mag = 2'd1; end
        else if (move[3]) begin dx_pos = 1'b0; dx_mag = 2'd2; dy_pos = 1'b0; dy_mag = 2'd1; end
        else if (move[4]) begin dx_pos = 1'b0; dx_mag = 2'd1; dy_pos = 1'b0; dy_mag = 2'd2; end
        else if (move[5]) begin dx_pos = 1'b1; dx_mag = 2'd1; dy_pos = 1'b0; dy_mag = 2'd2; end
        else if (move[6]) begin dx_pos = 1'b1; dx_mag = 2'd2; dy_pos = 1'b0; dy_mag = 2'd1; end
        else if (move[7]) begin dx_pos = 1'b1; dx_mag = 2'd2; dy_pos = 1'b1; dy_mag = 2'd1; end
        else              move_none = 1'b1;
    end

    assign vert_cmd = {4'h2, (dy_pos ? 8'h00 : 8'h7F), 2'b00, dy_mag};
    assign horz_cmd = {4'h3, (dx_pos ? 8'hBF : 8'h3F), 2'b00, dx_mag};
    assign at_last  = (mv_indx_q == LAST_IDX);

    always_comb begin
        state_d          = state_q;
        mv_indx_d        = mv_indx_q;
        last_cmd_d       = last_cmd_q;
        cmd              = last_cmd_q;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = 8'h5A;
        case (state_q)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = 8'hA5;
                if (start_tour) begin
                    state_d   = VERT;
                    mv_indx_d = '0;
                end
            end
            VERT: begin
                // An empty move means the tour data is bad. Give up the
                // tour without offering a command.
                if (move_none) begin
                    state_d = IDLE;
                end else begin
                    cmd        = vert_cmd;
                    cmd_rdy    = 1'b1;
                    last_cmd_d = vert_cmd;
                    if (clr_cmd_rdy) state_d = HOLDV;
                end
            end
            HOLDV: begin
                if (send_resp) state_d = HORZ;
            end
            HORZ: begin
                cmd        = horz_cmd;
                cmd_rdy    = 1'b1;
                last_cmd_d = horz_cmd;
                if (clr_cmd_rdy) state_d = HOLDH;
            end
            HOLDH: begin
                if (at_last) resp = 8'hA5;
                if (send_resp) begin
                    if (at_last) begin
                        state_d = IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + 5'd1;
                        state_d   = VERT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mv_indx_q  <= '0;
            last_cmd_q <= '0;
        end else begin
            state_q    <= state_d;
            mv_indx_q  <= mv_indx_d;
            last_cmd_q <= last_cmd_d;
        end
    end

    assign mv_indx = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd.sv
// tb_tour_cmd
// Self-checking bench for tour_cmd. The reference works at the command level.
// For each tour index it works out the expected vertical and horizontal
// commands from the knight-move table. It then walks the handshake with
// random stall lengths and random ignored strobes, and checks the outputs
// in every cycle.
module tb_tour_cmd;

    localparam int NUM_MOVES = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy_UART;
    logic [7:0]  resp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tm [NUM_MOVES];

    tour_cmd #(.NUM_MOVES(NUM_MOVES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .resp             (resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected command for one leg, built from (dx,dy) of the lowest set bit.
    function automatic logic [15:0] ref_cmd(input logic [7:0] mv, input bit vert);
        int dx_t [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
        int dy_t [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};
        int b = 0;
        int d;
        int mag;
        logic [7:0] head;
        for (int i = 7; i >= 0; i--) if (mv[i]) b = i;
        d   = vert ? dy_t[b] : dx_t[b];
        mag = (d < 0) ? -d : d;
        if (vert) head = (d > 0) ? 8'h00 : 8'h7F;
        else      head = (d > 0) ? 8'hBF : 8'h3F;
        return {(vert ? 4'h2 : 4'h3), head, 4'(mag)};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_cmd"},  cmd, cmd_UART);
        check({tag, "_rdy"},  16'(cmd_rdy), 16'(cmd_rdy_UART));
        check({tag, "_resp"}, 16'(resp), 16'h00A5);
    endtask

    // mode 0: full tour, 1: empty move at stop_at, 2: reset in HORZ at stop_at
    task automatic run_tour(input int mode, input int stop_at);
        int hs = 0;
        logic [15:0] ev, eh;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        for (int idx = 0; idx < NUM_MOVES; idx++) begin
            move         = (mode == 1 && idx == stop_at) ? 8'h00 : tm[idx];
            cmd_UART     = 16'($urandom);
            cmd_rdy_UART = 1'($urandom);
            ev = ref_cmd(tm[idx], 1'b1);
            eh = ref_cmd(tm[idx], 1'b0);
            #1;
            if (mode == 1 && idx == stop_at) begin
                check("zero_rdy", 16'(cmd_rdy), 16'h0000);
                tick();
                check_idle("zero_idle");
                check("zero_indx", 16'(mv_indx), 16'(idx));
                return;
            end
            check("v_indx", 16'(mv_indx), 16'(idx));
            check("v_rdy",  16'(cmd_rdy), 16'h0001);
            check("v_cmd",  cmd, ev);
            check("v_resp", 16'(resp), 16'h005A);
            repeat ($urandom_range(0, 2)) begin
                send_resp = 1'($urandom);
                tick();
                send_resp = 1'b0;
                #1;
                check("v_stall_rdy", 16'(cmd_rdy), 16'h0001);
                check("v_stall_cmd", cmd, ev);
            end
            clr_cmd_rdy = 1'b1;
            send_resp   = 1'($urandom);
            #1;
            check("v_clr_uart", 16'(clr_cmd_rdy_UART), 16'h0000);
            tick();
            clr_cmd_rdy = 1'b0;
            send_resp   = 1'b0;
            hs++;
            #1;
            check("hv_rdy",  16'(cmd_rdy), 16'h0000);
            check("hv_cmd",  cmd, ev);
            check("hv_resp", 16'(resp), 16'h005A);
            repeat ($urandom_range(0, 2)) begin
                start_tour = 1'($urandom);
                tick();
                start_tour = 1'b0;
                #1;
                check("hv_stall_rdy",  16'(cmd_rdy), 16'h0000);
                check("hv_stall_indx", 16'(mv_indx), 16'(idx));
            end
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            #1;
            check("h_rdy", 16'(cmd_rdy), 16'h0001);
            check("h_cmd", cmd, eh);
            if (mode == 2 && idx == stop_at) begin
                #2 rst_n = 1'b0;
                #1;
                check_idle("rst_idle");
                check("rst_indx", 16'(mv_indx), 16'h0000);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                send_resp = 1'($urandom);
                tick();
                send_resp = 1'b0;
                #1;
                check("h_stall_cmd", cmd, eh);
            end
            clr_cmd_rdy = 1'b1;
            send_resp   = 1'($urandom);
            tick();
            clr_cmd_rdy = 1'b0;
            send_resp   = 1'b0;
            hs++;
            #1;
            check("hh_rdy",  16'(cmd_rdy), 16'h0000);
            check("hh_cmd",  cmd, eh);
            check("hh_resp", 16'(resp), (idx == NUM_MOVES - 1) ? 16'h00A5 : 16'h005A);
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
        end
        #1;
        check_idle("end_idle");
        check("end_indx", 16'(mv_indx), 16'(NUM_MOVES - 1));
        check("end_hs",   16'(hs), 16'(2 * NUM_MOVES));
    endtask

    task automatic new_moves();
        for (int i = 0; i < NUM_MOVES; i++) tm[i] = 8'($urandom_range(1, 255));
    endtask

    initial begin
        rst_n        = 1'b0;
        start_tour   = 1'b0;
        move         = 8'h01;
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        #12;
        check_idle("reset");
        check("reset_indx", 16'(mv_indx), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // UART pass-through
        tick();
        cmd_UART     = 16'h2005;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b1;
        #1;
        check_idle("pt");
        check("pt_clr", 16'(clr_cmd_rdy_UART), 16'h0001);
        tick();
        clr_cmd_rdy = 1'b0;
        #1;
        check("pt_clr_off", 16'(clr_cmd_rdy_UART), 16'h0000);
        for (int i = 0; i < 4; i++) begin
            cmd_UART     = 16'($urandom);
            cmd_rdy_UART = 1'($urandom);
            clr_cmd_rdy  = 1'($urandom);
            #1;
            check_idle("pt_rand");
            check("pt_rand_clr", 16'(clr_cmd_rdy_UART), 16'(clr_cmd_rdy));
            tick();
        end
        clr_cmd_rdy = 1'b0;

        new_moves();
        tm[0] = 8'h02;
        tm[1] = 8'h08;
        run_tour(0, 0);
        tick();
        run_tour(2, 7);
        run_tour(1, 0);
        tick();
        new_moves();
        run_tour(1, 5);
        tick();
        new_moves();
        tm[3] = 8'h80;
        tm[4] = 8'hF0;
        run_tour(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 Parameter: NUM_MOVES, 24, number of knight moves in a full tour; the last move index is NUM_MOVES-1.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start_tour  input  1  one-cycle pulse from cmd_proc that begins tour replay.
REQ-005 Port: move  input  8  one-hot knight move for the current mv_indx, supplied by tour logic.
REQ-006 Port: mv_indx  output  5  index of the move currently being replayed.
REQ-007 Port: cmd_UART  input  16  command from the UART wrapper.
REQ-008 Port: cmd_rdy_UART  input  1  UART command valid.
REQ-009 Port: clr_cmd_rdy  input  1  cmd_proc has consumed cmd.
REQ-010 Port: send_resp  input  1  cmd_proc has finished the command and requests a response.
REQ-011 Port: cmd  output  16  command to cmd_proc; [15:12] opcode, [11:4] heading, [3:0] squares.
REQ-012 Port: cmd_rdy  output  1  cmd valid to cmd_proc.
REQ-013 Port: clr_cmd_rdy_UART  output  1  consume strobe forwarded to the UART wrapper.
REQ-014 Port: resp  output  8  response byte to the UART wrapper.

Function
REQ-015 States SHALL be IDLE, VERT, HOLDV, HORZ and HOLDH, with one registered state and a registered 5-bit mv_indx.
REQ-016 IDLE, UART pass-through:
- cmd = cmd_UART
- cmd_rdy = cmd_rdy_UART
- clr_cmd_rdy_UART = clr_cmd_rdy
REQ-017 Outside IDLE, clr_cmd_rdy_UART SHALL be 0 and cmd_UART/cmd_rdy_UART SHALL be ignored.
REQ-018 IDLE with start_tour=1: next state VERT, mv_indx <= 0; start_tour outside IDLE SHALL be ignored.
REQ-019 Move decode, lowest set bit wins, as (dx,dy):
- b0 (-1,+2), b1 (+1,+2), b2 (-2,+1), b3 (-2,-1)
- b4 (-1,-2), b5 (+1,-2), b6 (+2,-1), b7 (+2,+1)
REQ-020 VERT (combinational outputs):
- cmd_rdy=1
- cmd = {4'h2, heading, |dy|}
- heading 8'h00 (north) if dy>0, else 8'h7F (south)
REQ-021 HORZ (combinational outputs):
- cmd_rdy=1
- cmd = {4'h3, heading, |dx|}
- heading 8'hBF (east) if dx>0, else 8'h3F (west)
REQ-022 VERT or HORZ with clr_cmd_rdy=1: advance to HOLDV or HOLDH respectively; otherwise hold with cmd_rdy=1 and cmd stable.
REQ-023 In HOLDV and HOLDH, cmd_rdy SHALL be 0 and cmd SHALL keep the last issued value.
REQ-024 HOLDV with send_resp=1: go to HORZ.
REQ-025 HOLDH with send_resp=1:
- mv_indx==NUM_MOVES-1: go to IDLE, mv_indx holds
- otherwise: mv_indx increments, go to VERT
REQ-026 resp values:
- 8'hA5 in IDLE, and in HOLDH when mv_indx==NUM_MOVES-1
- 8'h5A otherwise
REQ-027 move==8'h00 while in VERT: go to IDLE next cycle, mv_indx unchanged; cmd_rdy SHALL be 0 in that cycle.
REQ-028 Simultaneous clr_cmd_rdy and send_resp in VERT or HORZ: only clr_cmd_rdy acts; send_resp is dropped.
REQ-029 Latency: cmd_rdy SHALL assert in the cycle after start_tour, and in the cycle after the qualifying send_resp.

Reset
REQ-030 rst_n low SHALL asynchronously force:
- state IDLE
- mv_indx 0
- resulting outputs cmd_rdy=cmd_rdy_UART, cmd=cmd_UART, resp=8'hA5
REQ-031 Reset mid-tour SHALL abandon the tour with no further tour commands; the next start_tour restarts at mv_indx 0.

Verification
REQ-032 IDLE, cmd_UART=16'h2005, cmd_rdy_UART=1, pulse clr_cmd_rdy -> cmd=16'h2005, cmd_rdy=1, clr_cmd_rdy_UART pulses with clr_cmd_rdy.
REQ-033 start_tour, move=8'h02:
- next cycle cmd=16'h2002, cmd_rdy=1
- after clr_cmd_rdy and send_resp, cmd=16'h3BF1
- resp=8'h5A
REQ-034 move=8'h08:
- vertical cmd=16'h27F1
- horizontal cmd=16'h33F2
REQ-035 Full 24-move replay -> mv_indx 0..23 in order, 48 cmd_rdy handshakes, resp=8'hA5 in final HOLDH, then return to IDLE.
REQ-036 rst_n low in HORZ at mv_indx=7 -> immediate IDLE, mv_indx=0, UART pass-through restored.
REQ-037 Robustness:
- start_tour pulsed in HOLDV -> no effect
- move=8'h00 in VERT -> IDLE without cmd_rdy
